unpooling_layer: RTL and testbench
==================================

Name: unpooling_layer

Overview:
Streaming upsampler for the CNN datapath. It is the inverse of the pooling stage: it accepts a pooled feature map in raster order and expands each value into a POOL_SIZE x POOL_SIZE block of identical pixels, scaled by a Q16.15 multiplier. It emits the upsampled map in raster order over valid/ready handshakes, using a single pooled-row buffer.

Parameters:
INPUT_SIZE, 4, pooled map edge length (rows = cols); >= 1
POOL_SIZE, 2, upsampling factor per axis; >= 1
DATA_WIDTH, 32, word width; sign-magnitude fixed point, MSB = sign
FRAC_BITS, 15, fractional bits of data and multiplier (Q16.15)

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous active-high reset
unpool_multiplier  in  32  Q16.15 sign-magnitude scale; sampled on first accepted input of each frame
in_valid  in  1  input word valid
in_ready  out  1  block can accept an input word
in_data  in  32  pooled value, raster order
out_valid  out  1  output word valid
out_ready  in  1  downstream accepts output word
out_data  out  32  upsampled, scaled pixel
out_last  out  1  asserted with the final pixel of a frame
overflow  out  1  sticky: a product magnitude exceeded 31 bits in the current frame

Behaviour:
- Reset (synchronous, takes priority over everything, including mid-frame): state = LOAD, all counters 0, in_ready=1, out_valid=0, out_data=0, out_last=0, overflow=0. Row buffer contents are don't-care. Any partial frame is discarded.
- Input transfer: in_valid & in_ready on a rising edge. Output transfer: out_valid & out_ready.
- Arithmetic (applied on input accept, result stored in row buffer):
  - sign = in_data[31] ^ mult_q[31]
  - full = |in_data[30:0]| * |mult_q[30:0]| (62 bits), mag = full[45:15] (truncate)
  - overflow set if full[61:46] != 0
  - A zero magnitude yields sign 0 (no negative zero).
- mult_q: register loaded from unpool_multiplier when an input is accepted with row_cnt=0 and in_col=0. Changes on unpool_multiplier mid-frame are ignored.
- overflow clears at that same first-accept of a new frame. If the first product itself overflows, overflow=1.
- FSM:
  - LOAD: in_ready=1. Each accept writes the product to buf[in_col], then in_col++. On the accept with in_col=INPUT_SIZE-1: in_col=0, go to EMIT. in_ready drops the next cycle.
  - EMIT: in_ready=0. Walk sub_row 0..POOL_SIZE-1 (outer) and out_col 0..INPUT_SIZE*POOL_SIZE-1 (inner). Each pixel presents buf[out_col / POOL_SIZE].
  - After the last pixel of the last sub_row transfers:
    - if row_cnt < INPUT_SIZE-1: row_cnt++, go to LOAD.
    - else: row_cnt=0, go to LOAD (next frame).
- Output register: out_data, out_valid and out_last load only when !out_valid | out_ready (no bubble under continuous ready). Data must be held stable while out_valid & !out_ready.
- out_last=1 only for pixel (sub_row=POOL_SIZE-1, out_col=last) of row_cnt=INPUT_SIZE-1.
- Latency:
  - first out_valid rises 1 cycle after the transfer of a row's final input.
  - with out_ready held high: one pixel per cycle, INPUT_SIZE*POOL_SIZE^2 pixels per pooled row.
  - in_ready returns 1 the cycle after the last pixel of the row transfers.
- Boundaries:
  - INPUT_SIZE=1 and/or POOL_SIZE=1 must work (POOL_SIZE=1 is a pure scaler with row buffering).
  - Counters never wrap past their terminal values.
  - in_valid during EMIT is ignored (not accepted).

Test Plan:
- INPUT_SIZE=2, POOL_SIZE=2, mult=0x00008000 (1.0), inputs 0x8000, 0x10000, 0x18000, 0x20000, out_ready=1 -> 16 outputs in rows {8000,8000,10000,10000} x2 then {18000,18000,20000,20000} x2; out_last only on 16th; overflow=0.
- Sign/scale: mult=0x00004000 (0.5), input 0x80010000 (-2.0) -> each copy 0x80008000. Input 0x80000000 (-0) -> 0x00000000.
- Overflow: mult=0x00010000 (2.0), input 0x40000000 -> overflow=1, out_data magnitude truncated (0x00000000), sticky to frame end; next frame first accept with clean data -> overflow=0.
- Backpressure: toggle out_ready pseudo-randomly during EMIT -> out_data/out_last stable while stalled, no pixel dropped or duplicated, order identical to first test.
- Multiplier latch: change unpool_multiplier to 0x00010000 after first accept -> all frame outputs use 1.0; in_valid held high during EMIT -> no extra accepts (in_ready=0).
- Reset mid-EMIT (after 5 outputs): the next cycle shows out_valid=0, in_ready=1, overflow=0; a fresh frame then produces the exact first-test sequence.

Source files
------------

// File: rtl/unpooling_layer.sv
// Streaming unpooling stage: buffers one pooled row of scaled values, then
// replays it as POOL_SIZE x POOL_SIZE pixel blocks in raster order.
module unpooling_layer #(
  parameter int INPUT_SIZE = 4,
  parameter int POOL_SIZE  = 2,
  parameter int DATA_WIDTH = 32,
  parameter int FRAC_BITS  = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] unpool_multiplier,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  overflow
);
  localparam int M  = DATA_WIDTH - 1;                      // magnitude bits
  localparam int IW = (INPUT_SIZE > 1) ? $clog2(INPUT_SIZE) : 1;
  localparam int PW = (POOL_SIZE  > 1) ? $clog2(POOL_SIZE)  : 1;
  localparam logic [IW-1:0] IN_LAST = IW'(INPUT_SIZE - 1);
  localparam logic [PW-1:0] P_LAST  = PW'(POOL_SIZE - 1);

  typedef enum logic {LOAD, EMIT} state_t;
  state_t state, state_nx;

  logic [IW-1:0]         in_col, row_cnt, bidx;
  logic [PW-1:0]         sub_row, rep;
  logic                  gen_done;
  logic [DATA_WIDTH-1:0] mult_q;
  logic [DATA_WIDTH-1:0] rbuf [2**IW];

  logic                  in_xfer, out_xfer, first_acc, load_px, row_done, gen_last;
  logic [DATA_WIDTH-1:0] mult_use, prod;
  logic [2*M-1:0]        full;
  logic [M-1:0]          mag;
  logic                  prod_ovf;

  assign in_ready  = (state == LOAD);
  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = out_valid & out_ready;
  assign first_acc = in_xfer && (row_cnt == '0) && (in_col == '0);

  // The frame's first word must already use the new multiplier, so bypass mult_q.
  assign mult_use = first_acc ? unpool_multiplier : mult_q;
  assign full     = (2*M)'(in_data[M-1:0]) * (2*M)'(mult_use[M-1:0]);
  assign mag      = full[FRAC_BITS+M-1:FRAC_BITS];
  assign prod_ovf = |full[2*M-1:FRAC_BITS+M];
  // Zero magnitude is forced positive so -0 never leaves the block.
  assign prod     = {(in_data[M] ^ mult_use[M]) & (|mag), mag};

  // gen_* counters point at the next pixel to load into the output register.
  assign gen_last = (sub_row == P_LAST) && (bidx == IN_LAST) && (rep == P_LAST);
  assign load_px  = (state == EMIT) && !gen_done && (!out_valid || out_ready);
  // Row is finished once the last pixel (already loaded) leaves the register.
  assign row_done = (state == EMIT) && gen_done && out_xfer;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= LOAD;
    else       state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      LOAD: if (in_xfer && in_col == IN_LAST) state_nx = EMIT;
      EMIT: if (row_done) state_nx = LOAD;
      default: state_nx = LOAD;
    endcase
  end

  // Row buffer write; contents need no reset.
  always_ff @(posedge clk) begin
    if (in_xfer) rbuf[in_col] <= prod;
  end

  // Counters, multiplier latch, sticky overflow and the output register.
  always_ff @(posedge clk) begin
    if (reset) begin
      in_col    <= '0;
      row_cnt   <= '0;
      bidx      <= '0;
      rep       <= '0;
      sub_row   <= '0;
      gen_done  <= 1'b0;
      mult_q    <= '0;
      overflow  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else begin
      if (in_xfer) begin
        in_col <= (in_col == IN_LAST) ? '0 : in_col + 1'b1;
        if (first_acc) begin
          mult_q   <= unpool_multiplier;
          overflow <= prod_ovf;
        end else begin
          overflow <= overflow | prod_ovf;
        end
      end

      if (load_px) begin
        out_data  <= rbuf[bidx];
        out_valid <= 1'b1;
        out_last  <= gen_last && (row_cnt == IN_LAST);
        if (rep != P_LAST) rep <= rep + 1'b1;
        else begin
          rep  <= '0;
          bidx <= (bidx == IN_LAST) ? '0 : bidx + 1'b1;
          if (bidx == IN_LAST) begin
            if (sub_row != P_LAST) sub_row <= sub_row + 1'b1;
            else begin
              sub_row  <= '0;
              gen_done <= 1'b1;
            end
          end
        end
      end else if (out_xfer) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end

      if (row_done) begin
        gen_done <= 1'b0;
        row_cnt  <= (row_cnt == IN_LAST) ? '0 : row_cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_unpooling_layer.sv
// Directed bench: per-frame vector table (multiplier, pooled inputs,
// hand-computed products, overflow) plus reset sequences.
module tb_unpooling_layer;
  localparam int IS   = 2;
  localparam int PS   = 2;
  localparam int NROW = IS * PS * PS;   // pixels per pooled row

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] unpool_multiplier, in_data, out_data;
  logic        in_valid, in_ready, out_valid, out_ready, out_last, overflow;

  always #5 clk = ~clk;

  unpooling_layer #(.INPUT_SIZE(IS), .POOL_SIZE(PS), .DATA_WIDTH(32), .FRAC_BITS(15)) dut (
    .clk(clk), .reset(reset), .unpool_multiplier(unpool_multiplier),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .overflow(overflow)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0]      mult;
    logic [3:0][31:0] din;
    logic [3:0][31:0] exp;
    logic             ovf;
    logic             bp;
  } vec_t;

  vec_t tbl[6];

  function automatic vec_t mk(input logic [31:0] m,
                              input logic [31:0] d0, d1, d2, d3,
                              input logic [31:0] e0, e1, e2, e3,
                              input logic o, input logic b);
    vec_t v;
    v.mult = m;
    v.din[0] = d0; v.din[1] = d1; v.din[2] = d2; v.din[3] = d3;
    v.exp[0] = e0; v.exp[1] = e1; v.exp[2] = e2; v.exp[3] = e3;
    v.ovf = o;
    v.bp  = b;
    return v;
  endfunction

  // Present one input word at a negedge and wait (bounded) for its accept.
  task automatic send(input logic [31:0] d);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL send_timeout actual=%0d cycles required=<50", n);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Collect n pixels of pooled row `row`, holding in_valid high with junk.
  task automatic collect(input vec_t v, input int row, input int n);
    int          got = 0;
    int          cyc = 0;
    int          s, c;
    logic        stalled = 1'b0;
    logic [31:0] hd = '0;
    logic        hl = 1'b0;
    in_valid = 1'b1;
    in_data  = 32'hDEAD_BEEF;
    while (got < n && cyc < 200) begin
      if (stalled) begin
        chk("hold_data", out_data, hd);
        chk("hold_last", 32'(out_last), 32'(hl));
      end
      chk("in_ready_emit", 32'(in_ready), 32'd0);
      out_ready = v.bp ? ((cyc % 3 == 2) ? 1'b1 : 1'($urandom_range(0, 1))) : 1'b1;
      if (out_valid && out_ready) begin
        s = got / (IS * PS);
        c = got % (IS * PS);
        chk("pixel_data", out_data, v.exp[row * IS + c / PS]);
        chk("pixel_last", 32'(out_last), 32'((row == IS - 1) && (s == PS - 1) && (c == IS * PS - 1)));
        got++;
        if (got == n) in_valid = 1'b0;
      end
      stalled = out_valid && !out_ready;
      hd = out_data;
      hl = out_last;
      @(negedge clk);
      cyc++;
    end
    if (got < n) begin
      checks++; errors++;
      $display("FAIL collect_timeout actual=%0d pixels required=%0d", got, n);
    end
    in_valid = 1'b0;
    if (!v.bp && n == NROW) chk("row_latency", 32'(cyc), 32'(NROW + 1));
    if (n == NROW) begin
      chk("in_ready_after_row", 32'(in_ready), 32'd1);
      chk("out_valid_after_row", 32'(out_valid), 32'd0);
    end
  endtask

  // Whole frame; the multiplier input is scrambled after the first accept.
  task automatic run_frame(input vec_t v);
    unpool_multiplier = v.mult;
    for (int r = 0; r < IS; r++) begin
      for (int c = 0; c < IS; c++) begin
        send(v.din[r * IS + c]);
        if (r == 0 && c == 0) unpool_multiplier = v.mult ^ 32'h0001_8000;
      end
      collect(v, r, NROW);
    end
    chk("frame_overflow", 32'(overflow), 32'(v.ovf));
  endtask

  initial begin
    // 1.0 passthrough
    tbl[0] = mk(32'h0000_8000, 32'h8000, 32'h10000, 32'h18000, 32'h20000,
                32'h8000, 32'h10000, 32'h18000, 32'h20000, 1'b0, 1'b0);
    // 0.5: -2.0 -> -1.0, -0 -> +0, 2.0 -> 1.0, tiny 2 -> 1
    tbl[1] = mk(32'h0000_4000, 32'h8001_0000, 32'h8000_0000, 32'h0001_0000, 32'h0000_0002,
                32'h8000_8000, 32'h0000_0000, 32'h0000_8000, 32'h0000_0001, 1'b0, 1'b0);
    // 2.0: 0x40000000 overflows to 0, sticky through the frame
    tbl[2] = mk(32'h0001_0000, 32'h4000_0000, 32'h0000_0001, 32'h0000_8000, 32'h8000_0001,
                32'h0000_0000, 32'h0000_0002, 32'h0001_0000, 32'h8000_0002, 1'b1, 1'b0);
    // clean frame after overflow frame: flag clears
    tbl[3] = mk(32'h0000_8000, 32'h1, 32'h2, 32'h3, 32'h4,
                32'h1, 32'h2, 32'h3, 32'h4, 1'b0, 1'b0);
    // first-test sequence under backpressure
    tbl[4] = mk(32'h0000_8000, 32'h8000, 32'h10000, 32'h18000, 32'h20000,
                32'h8000, 32'h10000, 32'h18000, 32'h20000, 1'b0, 1'b1);
    // -1.0 with max magnitude, under backpressure
    tbl[5] = mk(32'h8000_8000, 32'h0000_8000, 32'h8000_8000, 32'h0000_0000, 32'h7FFF_FFFF,
                32'h8000_8000, 32'h0000_8000, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1);

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0; unpool_multiplier = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);

    for (int i = 0; i < 6; i++) run_frame(tbl[i]);

    // Reset in the middle of EMIT after an overflowing first product.
    unpool_multiplier = tbl[2].mult;
    send(tbl[2].din[0]);
    send(tbl[2].din[1]);
    chk("pre_reset_overflow", 32'(overflow), 32'd1);
    collect(tbl[2], 0, 5);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_overflow", 32'(overflow), 32'd0);
    chk("mid_rst_out_last", 32'(out_last), 32'd0);
    run_frame(tbl[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
